alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU for the ARM processor datapath with a start/done handshake. Single-cycle arithmetic and logic operations return a result one cycle after issue. A multiply takes WIDTH cycles using an iterative shift-add engine. The block holds its result and its NZCV flags in registers until the next completed operation, so the control unit can stall on `busy` while a multiply runs.

## Interface
- `WIDTH`, default 32: operand and result width; legal range 4 to 64.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: issue request; sampled only while `busy`=0.
- `ALUControl` input 3: operation code, sampled with `start`.
- `SrcA` input WIDTH: operand A, sampled with `start`.
- `SrcB` input WIDTH: operand B, sampled with `start`.
- `busy` output 1: a multiply is in progress; new `start` is ignored.
- `done` output 1: one-cycle pulse; `ALUResult`/`ALUFlags` were updated at the same edge.
- `ALUResult` output WIDTH: registered result.
- `ALUFlags` output 4: registered {N,Z,C,V}, bit 3 = N.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 ORR.
  - 100 EOR.
  - 101 MUL: low WIDTH bits of A×B, unsigned.
  - 110, 111 reserved.
- State machine has two states, IDLE and MUL.
  - IDLE with `start`=1 and opcode ≠ 101: compute, register result and flags, pulse `done`; stay in IDLE.
  - IDLE with `start`=1 and opcode = 101: capture multiplicand = A, multiplier = B, accumulator = 0, step counter = 0; go to MUL; `busy`=1.
  - MUL, each cycle: if multiplier[0]=1, accumulator += multiplicand (mod 2^WIDTH). Then multiplicand <<= 1, multiplier >>= 1, counter += 1. The counter is $clog2(WIDTH)+1 bits wide.
  - MUL, step WIDTH: write accumulator to `ALUResult`, update flags, pulse `done`, return to IDLE, `busy`=0.
- Flags:
  - N = result[WIDTH−1]; Z = (result == 0).
  - ADD: C = carry out of bit WIDTH−1; V = signed overflow (operands same sign, result sign differs).
  - SUB: computed as A + ~B + 1. C = carry out, so C=1 means no borrow. V = operands differ in sign and result sign ≠ A sign.
  - AND/ORR/EOR/MUL: C and V keep their previous register values.
  - Reserved opcodes: result 0, flags 0100; `done` pulses as for a single-cycle op.
- `start` while `busy`=1 is ignored entirely. The operation is not queued and no `done` is produced for it.
- `ALUResult` and `ALUFlags` change only on a `done` edge or on reset. Between operations they hold.

## Timing
- Reset (any state, including mid-multiply) clears, at the next edge:
  - `ALUResult`=0, `ALUFlags`=0000, `busy`=0, `done`=0.
  - State = IDLE; the accumulator and counter are cleared.
  - An aborted multiply never produces `done`.
- `start` asserted together with `reset`: reset wins and the request is dropped.
- Single-cycle ops:
  - `start` is sampled at edge E0.
  - Result, flags and `done`=1 are visible after E0, so latency is 1.
  - `done` falls after E1 unless a new op completes at E1.
  - Back-to-back issue every cycle is legal and gives `done` every cycle.
- MUL:
  - `start` is sampled at E0; `busy`=1 after E0.
  - Steps happen at E1..E_WIDTH.
  - Result and `done`=1 are visible after E_WIDTH, and `busy`=0 at the same time. Latency is WIDTH cycles.
- A new `start` may be sampled on the same edge at which `done` is visible, because `busy` is already 0 then.
- `SrcA`/`SrcB`/`ALUControl` may change freely after the issue edge.

## Test plan
- ADD, WIDTH=32: 0x7FFFFFFF + 0x00000001 → `ALUResult`=0x80000000, NZCV=1001, `done` high exactly the one cycle after issue. Then 0xFFFFFFFF + 0x00000001 → 0x00000000, NZCV=0110.
- SUB: 5−5 → 0x00000000, NZCV=0110. 3−5 → 0xFFFFFFFE, NZCV=1000. 0x80000000−1 → 0x7FFFFFFF, NZCV=0011.
- MUL after a prior ADD left C=1, V=1: 0x0000FFFF × 0x0000FFFF → 0xFFFE0001, NZCV=1011.
  - `busy` is high for exactly 32 cycles.
  - `done` is visible 32 edges after issue.
  - `ALUResult` is unchanged while `busy` is high.
- Busy collision: issue MUL 7×6, then assert `start` with ADD 1+1 on cycle 5 → ADD ignored; the only `done` carries 42 (0x2A).
- Reset on step 10 of a MUL → all outputs 0 at the next edge, no `done` for that MUL. ADD 2+2 issued immediately after → 4, NZCV=0000.
- Parameter sweep, WIDTH=8:
  - 0x0F × 0x11 → 0xFF, NZCV=10xx, with C,V retained; `done` after 8 edges.
  - Reserved opcode 111 → 0x00, NZCV=0100, latency 1.

Source files
------------

// File: rtl/alu_seq_if.sv
// ALU issue/result bundle: master drives start and operands, slave returns busy, done, result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  busy, done, ALUResult, ALUFlags
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output busy, done, ALUResult, ALUFlags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flags. Latency is 1 cycle for single-cycle ops and WIDTH cycles for MUL (shift-add).
// Backpressure: start is ignored while busy is high. Result and flags hold until the next done.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] res, res_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       flg, flg_n;
  logic             done_r, done_n;
  logic [WIDTH:0]   sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      res    <= '0;
      cnt    <= '0;
      flg    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      res    <= res_n;
      cnt    <= cnt_n;
      flg    <= flg_n;
      done_r <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    res_n    = res;
    cnt_n    = cnt;
    flg_n    = flg;
    done_n   = 1'b0;
    sum      = '0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          done_n = 1'b1;
          case (bus.ALUControl)
            OP_ADD: begin
              sum   = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
              res_n = sum[WIDTH-1:0];
              flg_n = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), sum[WIDTH],
                       (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.SrcA[WIDTH-1])};
            end
            OP_SUB: begin
              // A + ~B + 1 so that C reads as "no borrow"
              sum   = {1'b0, bus.SrcA} + {1'b0, ~bus.SrcB} + {{WIDTH{1'b0}}, 1'b1};
              res_n = sum[WIDTH-1:0];
              flg_n = {sum[WIDTH-1], (sum[WIDTH-1:0] == '0), sum[WIDTH],
                       (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.SrcA[WIDTH-1])};
            end
            OP_AND, OP_ORR, OP_EOR: begin
              if (bus.ALUControl == OP_AND)      res_n = bus.SrcA & bus.SrcB;
              else if (bus.ALUControl == OP_ORR) res_n = bus.SrcA | bus.SrcB;
              else                               res_n = bus.SrcA ^ bus.SrcB;
              flg_n = {res_n[WIDTH-1], (res_n == '0), flg[1:0]};
            end
            OP_MUL: begin
              done_n   = 1'b0;
              mcand_n  = bus.SrcA;
              mplier_n = bus.SrcB;
              acc_n    = '0;
              cnt_n    = '0;
              state_n  = MUL;
            end
            default: begin
              res_n = '0;
              flg_n = 4'b0100;
            end
          endcase
        end
      end
      MUL: begin
        acc_n    = mplier[0] ? (acc + mcand) : acc;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + CW'(1);
        // cnt counts completed steps, so WIDTH-1 here means this edge is step WIDTH
        if (cnt == CW'(WIDTH - 1)) begin
          res_n   = acc_n;
          flg_n   = {acc_n[WIDTH-1], (acc_n == '0), flg[1:0]};
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy      = (state == MUL);
  assign bus.done      = done_r;
  assign bus.ALUResult = res;
  assign bus.ALUFlags  = flg;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=32 and WIDTH=8 instances, table vectors plus multi-cycle corner sequences.
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          issue;
    int          diff;
  } sb_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          diff;
  } vec_t;

  sb_t  q32[$];
  sb_t  q8[$];
  vec_t tv32[11];
  vec_t tv8[4];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // done is sampled on the falling edge; each done pops one expected record
  always @(negedge clk) begin
    sb_t e;
    if (b32.done === 1'b1) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done32: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        chk("res32", 64'(b32.ALUResult), 64'(e.res));
        chk("flags32", 64'(b32.ALUFlags), 64'(e.fl));
        chk("lat32", 64'(cyc - e.issue), 64'(e.diff));
      end
    end
    if (b8.done === 1'b1) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done8: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("res8", 64'(b8.ALUResult), 64'(e.res[7:0]));
        chk("flags8", 64'(b8.ALUFlags), 64'(e.fl));
        chk("lat8", 64'(cyc - e.issue), 64'(e.diff));
      end
    end
  end

  task automatic iss32(input vec_t v, input bit push);
    sb_t e;
    b32.start = 1'b1; b32.ALUControl = v.op; b32.SrcA = v.a; b32.SrcB = v.b;
    if (push) begin
      e.res = v.res; e.fl = v.fl; e.issue = cyc + 1; e.diff = v.diff;
      q32.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic iss8(input vec_t v);
    sb_t e;
    b8.start = 1'b1; b8.ALUControl = v.op; b8.SrcA = v.a[7:0]; b8.SrcB = v.b[7:0];
    e.res = v.res; e.fl = v.fl; e.issue = cyc + 1; e.diff = v.diff;
    q8.push_back(e);
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() + q8.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q32.size() + q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   bc;

    tv32[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 0};
    tv32[1]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 0};
    tv32[2]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 0};
    tv32[3]  = '{3'b001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 0};
    tv32[4]  = '{3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 0};
    tv32[5]  = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0011, 0};
    tv32[6]  = '{3'b011, 32'h80000000, 32'h00000001, 32'h80000001, 4'b1011, 0};
    tv32[7]  = '{3'b100, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0111, 0};
    tv32[8]  = '{3'b110, 32'h00001234, 32'h00000005, 32'h00000000, 4'b0100, 0};
    tv32[9]  = '{3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 0};
    tv32[10] = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111, 0};

    tv8[0] = '{3'b000, 32'h80, 32'h80, 32'h00, 4'b0111, 0};
    tv8[1] = '{3'b101, 32'h0F, 32'h11, 32'hFF, 4'b1011, 8};
    tv8[2] = '{3'b111, 32'h5A, 32'h33, 32'h00, 4'b0100, 0};
    tv8[3] = '{3'b001, 32'h00, 32'h01, 32'hFF, 4'b1000, 0};

    b32.start = 1'b0; b32.ALUControl = '0; b32.SrcA = '0; b32.SrcB = '0;
    b8.start  = 1'b0; b8.ALUControl  = '0; b8.SrcA  = '0; b8.SrcB  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_res", 64'(b32.ALUResult), 64'h0);
    chk("rst_flags", 64'(b32.ALUFlags), 64'h0);
    chk("rst_busy", 64'(b32.busy), 64'h0);
    chk("rst_done", 64'(b32.done), 64'h0);

    // back-to-back issue of every table entry
    for (int i = 0; i < 11; i++) iss32(tv32[i], 1'b1);
    b32.start = 1'b0;
    drain();

    // long multiply: busy window and result hold
    v = '{3'b101, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 4'b1011, 32};
    iss32(v, 1'b1);
    b32.start = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b32.done === 1'b1) break;
      if (b32.busy === 1'b1) begin
        bc++;
        chk("mul_hold", 64'(b32.ALUResult), 64'h0);
      end
    end
    chk("busy_cycles", 64'(bc), 64'd32);
    @(posedge clk); #1;
    drain();

    // collision: ADD while MUL is busy must vanish
    v = '{3'b101, 32'd7, 32'd6, 32'h0000002A, 4'b0011, 32};
    iss32(v, 1'b1);
    b32.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_at_collision", 64'(b32.busy), 64'h1);
    v = '{3'b000, 32'd1, 32'd1, 32'd2, 4'b0000, 0};
    iss32(v, 1'b0);
    b32.start = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;

    // reset at step 10 of a multiply, with a start request riding the reset
    v = '{3'b101, 32'd3, 32'd3, 32'd9, 4'b0000, 32};
    iss32(v, 1'b1);
    b32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    b32.start = 1'b1; b32.ALUControl = 3'b000; b32.SrcA = 32'd1; b32.SrcB = 32'd1;
    q32.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    b32.start = 1'b0;
    chk("abort_res", 64'(b32.ALUResult), 64'h0);
    chk("abort_flags", 64'(b32.ALUFlags), 64'h0);
    chk("abort_busy", 64'(b32.busy), 64'h0);
    chk("abort_done", 64'(b32.done), 64'h0);
    v = '{3'b000, 32'd2, 32'd2, 32'd4, 4'b0000, 0};
    iss32(v, 1'b1);
    b32.start = 1'b0;
    drain();

    // narrow instance
    for (int i = 0; i < 4; i++) begin
      iss8(tv8[i]);
      drain();
    end

    repeat (40) @(posedge clk);
    #1;
    chk("q32_empty", 64'(q32.size()), 64'h0);
    chk("q8_empty", 64'(q8.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
